// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage controller: issues loads/stores over a req/ack bus, formats load data, stalls the pipe.
// Optional build macro MEM_TIMEOUT_EN adds a WAIT timeout that raises a sticky bus_err.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ex_valid,
  input  logic [31:0]        ex_alu_result,
  input  logic [31:0]        ex_store_data,
  input  logic [4:0]         ex_rd,
  input  logic               ex_mem_read,
  input  logic               ex_mem_write,
  input  logic               ex_reg_write,
  input  logic               ex_mem_to_reg,
  input  logic [1:0]         ex_size,
  input  logic               ex_unsigned,
  mem_access_stage_if.master dmem,
  output logic [31:0]        mem_d2,
  output logic [4:0]         mem_rd,
  output logic               mem_reg_write,
  output logic               mem_mem_to_reg,
  output logic               stall,
  output logic               misalign,
  output logic               bus_err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d;
  logic [3:0]  be_q, be_d;

  logic        mem_op, is_store, misaligned, timeout_hit, timed_out;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc, ld_fmt;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 1..255 to fit the 8-bit wait counter");
  end

  assign mem_op   = ex_valid & (ex_mem_read | ex_mem_write);
  assign is_store = ex_mem_write & ~ex_mem_read;   // read wins when both are set
  assign misaligned = ((ex_size == 2'b01) & ex_alu_result[0]) |
                      (ex_size[1] & (ex_alu_result[1:0] != 2'b00));

  always_comb begin
    case (ex_size)
      2'b00: begin
        be_calc    = 4'b0001 << ex_alu_result[1:0];
        wdata_calc = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        be_calc    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{ex_store_data[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = ex_store_data;
      end
    endcase
  end

  always_comb begin
    byte_lane = dmem.dmem_rdata[{ex_alu_result[1:0], 3'b000} +: 8];
    half_lane = ex_alu_result[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (ex_size)
      2'b00:   ld_fmt = ex_unsigned ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      2'b01:   ld_fmt = ex_unsigned ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: ld_fmt = dmem.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    we_d           = we_q;
    addr_d         = addr_q;
    be_d           = be_q;
    wdata_d        = wdata_q;
    ld_d           = ld_q;
    stall          = 1'b0;
    misalign       = 1'b0;
    mem_d2         = ex_alu_result;
    mem_rd         = ex_rd;
    mem_mem_to_reg = ex_mem_to_reg;
    mem_reg_write  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!mem_op) begin
          mem_reg_write = ex_reg_write & ex_valid;
        end else if (misaligned) begin
          misalign = 1'b1;
        end else begin
          stall   = 1'b1;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {ex_alu_result[31:2], 2'b00};
          be_d    = be_calc;
          wdata_d = wdata_calc;
          state_d = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (dmem.dmem_ack) begin
          ld_d    = ld_fmt;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = DONE;
        end else if (timeout_hit) begin
          ld_d    = 32'b0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        // Both pipeline registers advance at the end of this cycle, so no re-issue.
        if (ex_mem_read) begin
          mem_d2        = ld_q;
          mem_reg_write = ex_reg_write & ~timed_out;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'b0;
      be_q    <= 4'b0;
      wdata_q <= 32'b0;
      ld_q    <= 32'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       bus_err_q, bus_err_d, timed_out_q, timed_out_d;

  // Fires on the TIMEOUT_CYCLES-th WAIT cycle without an acknowledge.
  assign timeout_hit = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d       = cnt_q;
    bus_err_d   = bus_err_q;
    timed_out_d = timed_out_q;
    if (state_q == IDLE && state_d == WAIT) begin
      cnt_d       = 8'd0;
      timed_out_d = 1'b0;
    end else if (state_q == WAIT && !dmem.dmem_ack) begin
      if (timeout_hit) begin
        bus_err_d   = 1'b1;
        timed_out_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q       <= 8'd0;
      bus_err_q   <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bus_err_q   <= bus_err_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign bus_err   = bus_err_q;
  assign timed_out = timed_out_q;
`else
  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
  assign bus_err     = 1'b0;
`endif

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected MEM/WB results are queued at issue and
// compared whenever the stage retires an instruction (ex_valid high, stall low).
module tb_mem_access_stage;

  logic        clock, reset;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_unsigned;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_size;
  logic [31:0] mem_d2;
  logic [4:0]  mem_rd;
  logic        mem_reg_write, mem_mem_to_reg, stall, misalign, bus_err;

  mem_access_stage_if dmem();

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned),
    .dmem(dmem.master),
    .mem_d2(mem_d2), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_to_reg(mem_mem_to_reg), .stall(stall), .misalign(misalign), .bus_err(bus_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] d2;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  typedef struct {
    logic [31:0] addr, sdata, rdata, exp_wdata, exp_d2;
    logic [4:0]  rd;
    logic        rd_en, wr_en, rw, exp_we, exp_mis, exp_rw, uns;
    logic [1:0]  size;
    logic [3:0]  exp_be;
    int          ack_cycle, exp_stall;
  } op_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic op_t mk(input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd,
                             input logic rd_en, input logic wr_en, input logic rw,
                             input logic [1:0] size, input logic uns, input logic [31:0] rdata,
                             input int ack_cycle, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input logic exp_we, input logic exp_mis,
                             input logic [31:0] exp_d2, input logic exp_rw, input int exp_stall);
    op_t o;
    o.addr = addr; o.sdata = sdata; o.rd = rd; o.rd_en = rd_en; o.wr_en = wr_en; o.rw = rw;
    o.size = size; o.uns = uns; o.rdata = rdata; o.ack_cycle = ack_cycle; o.exp_be = exp_be;
    o.exp_wdata = exp_wdata; o.exp_we = exp_we; o.exp_mis = exp_mis; o.exp_d2 = exp_d2;
    o.exp_rw = exp_rw; o.exp_stall = exp_stall;
    return o;
  endfunction

  // Retire monitor: every instruction leaving the stage is compared with the queue head.
  always @(negedge clock) begin
    if (!reset && ex_valid && !stall) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_retire", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("retire_d2", mem_d2, e.d2);
        check("retire_rd", {27'b0, mem_rd}, {27'b0, e.rd});
        check("retire_rw", {31'b0, mem_reg_write}, {31'b0, e.rw});
      end
    end
  end

  task automatic drive_op(input op_t o);
    ex_valid      = 1'b1;
    ex_alu_result = o.addr;
    ex_store_data = o.sdata;
    ex_rd         = o.rd;
    ex_mem_read   = o.rd_en;
    ex_mem_write  = o.wr_en;
    ex_reg_write  = o.rw;
    ex_mem_to_reg = o.rd_en;
    ex_size       = o.size;
    ex_unsigned   = o.uns;
  endtask

  task automatic run_op(input string name, input op_t o);
    int  stalls, reqs;
    bit  done;
    logic [31:0] exp_addr;
    exp_addr = {o.addr[31:2], 2'b00};
    stalls = 0; reqs = 0; done = 1'b0;
    @(posedge clock); #1;
    drive_op(o);
    sb_q.push_back('{d2: o.exp_d2, rd: o.rd, rw: o.exp_rw});
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clock);
      dmem.dmem_ack = 1'b0;
      if (c == 0) check({name, "_misalign"}, {31'b0, misalign}, {31'b0, o.exp_mis});
      if (stall) begin
        stalls++;
        check({name, "_bubble_rw"}, {31'b0, mem_reg_write}, 32'd0);
        if (dmem.dmem_req) begin
          reqs++;
          check({name, "_addr"}, dmem.dmem_addr, exp_addr);
          check({name, "_be"}, {28'b0, dmem.dmem_be}, {28'b0, o.exp_be});
          check({name, "_we"}, {31'b0, dmem.dmem_we}, {31'b0, o.exp_we});
          if (o.exp_we) check({name, "_wdata"}, dmem.dmem_wdata, o.exp_wdata);
          if (reqs == o.ack_cycle) begin
            dmem.dmem_ack   = 1'b1;
            dmem.dmem_rdata = o.rdata;
          end
        end
      end else begin
        done = 1'b1;
      end
    end
    if (!done) check({name, "_hang"}, 32'd0, 32'd1);
    check({name, "_stall_cycles"}, stalls, o.exp_stall);
    $display("[TB] %s addr=0x%08h d2=0x%08h rw=%0b stall=%0d", name, o.addr, mem_d2, mem_reg_write, stalls);
    @(posedge clock); #1;
    ex_valid = 1'b0;
    @(negedge clock);
    check({name, "_req_after"}, {31'b0, dmem.dmem_req}, 32'd0);
    check({name, "_we_after"}, {31'b0, dmem.dmem_we}, 32'd0);
  endtask

  initial begin
    op_t o;
    bit  seen;
    reset = 1'b1;
    ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0; ex_rd = '0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0; ex_mem_to_reg = 1'b0;
    ex_size = 2'b00; ex_unsigned = 1'b0;
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = '0;
    repeat (3) @(negedge clock);
    check("rst_req", {31'b0, dmem.dmem_req}, 32'd0);
    check("rst_we", {31'b0, dmem.dmem_we}, 32'd0);
    check("rst_addr", dmem.dmem_addr, 32'd0);
    check("rst_be", {28'b0, dmem.dmem_be}, 32'd0);
    check("rst_wdata", dmem.dmem_wdata, 32'd0);
    check("rst_bus_err", {31'b0, bus_err}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    reset = 1'b0;

    run_op("ld_word",   mk(32'h100, 0, 5'd3, 1, 0, 1, 2'b10, 0, 32'hDEADBEEF, 1, 4'b1111, 0, 0, 0, 32'hDEADBEEF, 1, 2));
    run_op("ld_byte_s", mk(32'h103, 0, 5'd4, 1, 0, 1, 2'b00, 0, 32'h80112233, 1, 4'b1000, 0, 0, 0, 32'hFFFFFF80, 1, 2));
    run_op("ld_byte_u", mk(32'h103, 0, 5'd5, 1, 0, 1, 2'b00, 1, 32'h80112233, 2, 4'b1000, 0, 0, 0, 32'h00000080, 1, 3));
    run_op("st_half",   mk(32'h202, 32'h0000ABCD, 5'd0, 0, 1, 0, 2'b01, 0, 0, 3, 4'b1100, 32'hABCDABCD, 1, 0, 32'h202, 0, 4));
    run_op("mis_word",  mk(32'h101, 0, 5'd6, 1, 0, 1, 2'b10, 0, 0, 1, 4'b0000, 0, 0, 1, 32'h101, 0, 0));
    run_op("ld_half_s", mk(32'h102, 0, 5'd8, 1, 0, 1, 2'b01, 0, 32'h80011234, 1, 4'b1100, 0, 0, 0, 32'hFFFF8001, 1, 2));
    run_op("st_byte",   mk(32'h001, 32'h12345678, 5'd9, 0, 1, 1, 2'b00, 0, 0, 2, 4'b0010, 32'h78787878, 1, 0, 32'h001, 0, 3));
    run_op("ld_rw_both", mk(32'h104, 32'h11111111, 5'd10, 1, 1, 1, 2'b10, 0, 32'h0BADF00D, 1, 4'b1111, 0, 0, 0, 32'h0BADF00D, 1, 2));
    run_op("mis_half",  mk(32'h203, 32'h5555, 5'd11, 0, 1, 0, 2'b01, 0, 0, 1, 4'b0000, 0, 0, 1, 32'h203, 0, 0));
    run_op("ld_half_u", mk(32'h100, 0, 5'd12, 1, 0, 1, 2'b01, 1, 32'h1234F00F, 1, 4'b0011, 0, 0, 0, 32'h0000F00F, 1, 2));
    run_op("ld_size11", mk(32'h108, 0, 5'd13, 1, 0, 1, 2'b11, 0, 32'hA5A55A5A, 2, 4'b1111, 0, 0, 0, 32'hA5A55A5A, 1, 3));
    run_op("alu_55",    mk(32'h55, 0, 5'd7, 0, 0, 1, 2'b10, 0, 0, 1, 4'b0000, 0, 0, 0, 32'h55, 1, 0));
    for (int i = 0; i < 4; i++) begin
      logic [31:0] v;
      logic        w;
      v = $urandom;
      w = 1'($urandom_range(0, 1));
      run_op("alu_rand", mk(v, 0, 5'($urandom_range(1, 31)), 0, 0, w, 2'b10, 0, 0, 1, 4'b0000, 0, 0, 0, v, w, 0));
    end

    // Reset in the middle of WAIT: request must drop at once and a late ack must be ignored.
    @(posedge clock); #1;
    drive_op(mk(32'h400, 0, 5'd2, 1, 0, 1, 2'b10, 0, 0, 1, 4'b1111, 0, 0, 0, 0, 1, 2));
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clock);
      if (dmem.dmem_req) seen = 1'b1;
    end
    check("rst_wait_req_seen", {31'b0, seen}, 32'd1);
    #2 reset = 1'b1;
    #1 check("rst_wait_req_drop", {31'b0, dmem.dmem_req}, 32'd0);
    ex_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    dmem.dmem_ack = 1'b1;
    dmem.dmem_rdata = 32'hFFFFFFFF;
    @(negedge clock);
    dmem.dmem_ack = 1'b0;
    check("rst_late_ack_req", {31'b0, dmem.dmem_req}, 32'd0);
    check("rst_late_ack_stall", {31'b0, stall}, 32'd0);
    check("rst_late_ack_rw", {31'b0, mem_reg_write}, 32'd0);
    $display("[TB] reset_in_wait req=%0b stall=%0b", dmem.dmem_req, stall);
    run_op("ld_after_rst", mk(32'h10C, 0, 5'd14, 1, 0, 1, 2'b10, 0, 32'h13579BDF, 1, 4'b1111, 0, 0, 0, 32'h13579BDF, 1, 2));

`ifdef MEM_TIMEOUT_EN
    run_op("ld_timeout", mk(32'h500, 0, 5'd15, 1, 0, 1, 2'b10, 0, 0, 0, 4'b1111, 0, 0, 0, 32'h0, 0, 5));
    check("bus_err_set", {31'b0, bus_err}, 32'd1);
    run_op("ld_post_err", mk(32'h504, 0, 5'd16, 1, 0, 1, 2'b10, 0, 32'h2468ACE0, 1, 4'b1111, 0, 0, 0, 32'h2468ACE0, 1, 2));
    check("bus_err_sticky", {31'b0, bus_err}, 32'd1);
`else
    check("bus_err_tied", {31'b0, bus_err}, 32'd0);
`endif

    check("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
